// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-master arbiter for the single data-memory port
// Optional feature: ARB_RR_EN selects round-robin arbitration instead of fixed CPU priority.
module dmem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [1:0]        dbg_size,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       owner_dbg;
    logic       we_q;
    logic       grant_dbg;

`ifdef ARB_RR_EN
    logic last_dbg;
    // On a tie the port that did not win last time gets the memory.
    assign grant_dbg = dbg_req & (~cpu_req | ~last_dbg);
`else
    assign grant_dbg = dbg_req & ~cpu_req;
`endif

    assign mem_we    = mem_en & we_q;
    assign busy      = (state != IDLE);
    assign cpu_stall = cpu_req & ~cpu_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            owner_dbg <= 1'b0;
            we_q      <= 1'b0;
            mem_en    <= 1'b0;
            mem_size  <= 2'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_done  <= 1'b0;
            dbg_done  <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
`ifdef ARB_RR_EN
            last_dbg  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req | dbg_req) begin
                        owner_dbg <= grant_dbg;
                        we_q      <= grant_dbg ? dbg_we    : cpu_we;
                        mem_size  <= grant_dbg ? dbg_size  : cpu_size;
                        mem_addr  <= grant_dbg ? dbg_addr  : cpu_addr;
                        mem_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
                        mem_en    <= 1'b1;
                        cnt       <= 4'(MEM_LAT - 1);
                        state     <= ACCESS;
`ifdef ARB_RR_EN
                        last_dbg  <= grant_dbg;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        // Last access cycle: mem_rdata is valid now.
                        mem_en <= 1'b0;
                        if (!we_q) begin
                            if (owner_dbg) dbg_rdata <= mem_rdata;
                            else           cpu_rdata <= mem_rdata;
                        end
                        if (owner_dbg) dbg_done <= 1'b1;
                        else           cpu_done <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    cpu_done <= 1'b0;
                    dbg_done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
